// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I OP/OP-IMM/LUI decode stage with a single-entry output register
//
// Purpose: decodes integer compute instructions into an ALU operation code,
// register indices and a sign-extended immediate, and holds the result in a
// one-entry pipeline register that feeds the execute stage.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             kills the held entry and discards the current input
//   in_valid/in_ready instruction handshake from fetch
//   in_instr          32-bit instruction word
//   out_valid/out_ready decoded-entry handshake to execute
//   out_alu_op        ALU operation code (see t_alu_op)
//   out_rd/rs1/rs2    register indices
//   out_imm           sign-extended immediate
//   out_use_imm       ALU operand b selects imm (1) or rs2 (0)
//   out_rd_we         register writeback enable
//   out_illegal       instruction not supported by this stage

module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  // Encoding is {funct7[5], funct3} so OP instructions map straight through.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } t_alu_op;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [4:0] f_rd;
  logic [2:0] funct3;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [6:0] f7;

  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign f7     = in_instr[31:25];

  t_alu_op        d_alu_op;
  logic [4:0]     d_rd;
  logic [4:0]     d_rs1;
  logic [4:0]     d_rs2;
  logic [XLEN-1:0] d_imm;
  logic           d_use_imm;
  logic           d_rd_we;
  logic           d_illegal;

  // Combinational decode of the incoming word.
  always_comb begin
    d_alu_op  = ALU_ADD;
    d_rd      = f_rd;
    d_rs1     = f_rs1;
    d_rs2     = f_rs2;
    d_imm     = '0;
    d_use_imm = 1'b0;
    d_rd_we   = 1'b0;
    d_illegal = 1'b1;

    case (opcode)
      OPC_OP: begin
        d_alu_op  = t_alu_op'({f7[5], funct3});
        d_rd_we   = 1'b1;
        d_illegal = !((f7 == F7_ZERO) ||
                      ((f7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        d_imm     = XLEN'($signed(in_instr[31:20]));
        d_use_imm = 1'b1;
        d_rd_we   = 1'b1;
        d_rs2     = '0;
        d_alu_op  = t_alu_op'({1'b0, funct3});
        // Only the right shift uses instr[30] to pick arithmetic; ADDI and
        // the other immediates ignore it.
        if ((funct3 == 3'b101) && f7[5]) begin
          d_alu_op = ALU_SRA;
        end
        case (funct3)
          3'b001:  d_illegal = (f7 != F7_ZERO);
          3'b101:  d_illegal = !((f7 == F7_ZERO) || (f7 == F7_ALT));
          default: d_illegal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        d_rs1     = '0;
        d_imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
        d_use_imm = 1'b1;
        d_rd_we   = 1'b1;
        d_illegal = 1'b0;
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase

    // Unsupported entries still flow down the pipe but must be inert.
    if (d_illegal) begin
      d_alu_op  = ALU_ADD;
      d_use_imm = 1'b0;
      d_rd_we   = 1'b0;
    end
  end

  logic load;
  logic valid_next;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // EMPTY/FULL state is out_valid itself; flush wins over every handshake.
  always_comb begin
    valid_next = out_valid;
    if (flush) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_alu_op  <= ALU_ADD;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_use_imm <= 1'b0;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      out_valid <= valid_next;
      if (load) begin
        out_alu_op  <= d_alu_op;
        out_rd      <= d_rd;
        out_rs1     <= d_rs1;
        out_rs2     <= d_rs2;
        out_imm     <= d_imm;
        out_use_imm <= d_use_imm;
        out_rd_we   <= d_rd_we;
        out_illegal <= d_illegal;
      end
    end
  end

endmodule
